// File: rtl/onchip_arb_pkg.sv
// Shared types and constants for the on-chip RAM arbiter.
//   ADDR_W / DATA_W / BE_W : default bus widths (word address, data, byte lanes)
//   state_e                : arbiter top-level state (zero-fill scrub, normal service)
//   port_idx_t             : index of one of the two requesters
package onchip_arb_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  typedef enum logic {
    ST_SCRUB,
    ST_SERVE
  } state_e;

  typedef logic port_idx_t;

endpackage

// File: rtl/onchip_mem_arbiter_if.sv
// One Avalon-MM requester link between a bus master and the arbiter.
//   master modport : requester side (drives address/byteenable/read/write/writedata)
//   slave modport  : arbiter side (drives readdata/readdatavalid/waitrequest)
interface onchip_mem_arbiter_if
  import onchip_arb_pkg::*;
#(
  parameter int ADDR_W = onchip_arb_pkg::ADDR_W,
  parameter int DATA_W = onchip_arb_pkg::DATA_W
);

  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
  logic                waitrequest;

  modport master (
    output address, byteenable, read, write, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output readdata, readdatavalid, waitrequest
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, purely combinational.
//   req[1:0]   : pending requests
//   last_grant : port granted most recently; loses a tie
//   gnt[1:0]   : one-hot grant (all zero when nothing is pending)
//   gnt_valid  : some port is granted
module rr_arb2
  import onchip_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_idx_t  last_grant,
  output logic [1:0] gnt,
  output logic       gnt_valid
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  assign gnt_valid = |req;

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares a single-port on-chip RAM (1-cycle read latency) between two
// Avalon-MM requesters with round-robin arbitration, fixed-latency read
// return, out-of-range protection and optional zero-fill after reset.
//   clk, reset_n      : clock, synchronous active-low reset
//   m0, m1            : requester links (slave modport)
//   mem_*             : RAM s1 port (address/byteenable/chipselect/write/
//                       writedata/clken out, readdata in)
//   scrub_busy        : high while the post-reset zero-fill runs
module onchip_mem_arbiter
  import onchip_arb_pkg::*;
#(
  parameter int DEPTH          = 40960,
  parameter int ADDR_W         = onchip_arb_pkg::ADDR_W,
  parameter int DATA_W         = onchip_arb_pkg::DATA_W,
  parameter int SCRUB_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  onchip_mem_arbiter_if.slave   m0,
  onchip_mem_arbiter_if.slave   m1,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata,
  output logic                  scrub_busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   scrub_cnt_q, scrub_cnt_d;
  port_idx_t           last_grant_q, last_grant_d;

  logic [1:0]          req, gnt;
  logic                gnt_valid;
  logic                serving;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W/8-1:0] sel_be;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_wr;
  logic                in_range;
  logic [1:0]          rd_acc;

  logic [1:0]          pend_rd_p1;
  logic                oor_p1;
  logic [DATA_W-1:0]   rd_data_p1;
  logic [DATA_W-1:0]   rd_hold0_q, rd_hold1_q;

  // Arbitration only runs in service; during reset or scrub nobody is granted.
  assign serving = reset_n && (state_q == ST_SERVE);
  assign req     = serving ? {m1.read | m1.write, m0.read | m0.write} : 2'b00;

  rr_arb2 u_rr_arb2 (
    .req        (req),
    .last_grant (last_grant_q),
    .gnt        (gnt),
    .gnt_valid  (gnt_valid)
  );

  assign sel_addr  = gnt[1] ? m1.address    : m0.address;
  assign sel_be    = gnt[1] ? m1.byteenable : m0.byteenable;
  assign sel_wdata = gnt[1] ? m1.writedata  : m0.writedata;
  assign sel_wr    = gnt[1] ? m1.write      : m0.write;
  assign in_range  = {1'b0, sel_addr} < DEPTH_X;

  // Read+write together counts as a write, so no data is returned for it.
  assign rd_acc = {gnt[1] & m1.read & ~m1.write, gnt[0] & m0.read & ~m0.write};

  assign mem_clken = 1'b1;

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    scrub_cnt_d  = scrub_cnt_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_SCRUB: begin
        scrub_cnt_d = scrub_cnt_q + ADDR_W'(1);
        if (scrub_cnt_q == LAST_ADDR) state_d = ST_SERVE;
      end
      ST_SERVE: begin
        if (gnt_valid) last_grant_d = gnt[1];
      end
      default: state_d = ST_SERVE;
    endcase
  end

  // RAM-side and handshake outputs; everything idles while reset_n is low.
  always_comb begin
    mem_address    = sel_addr;
    mem_byteenable = sel_be;
    mem_writedata  = sel_wdata;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    scrub_busy     = 1'b0;
    m0.waitrequest = 1'b1;
    m1.waitrequest = 1'b1;
    if (reset_n) begin
      if (state_q == ST_SCRUB) begin
        mem_address    = scrub_cnt_q;
        mem_byteenable = '1;
        mem_writedata  = '0;
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
        scrub_busy     = 1'b1;
      end else begin
        m0.waitrequest = ~gnt[0];
        m1.waitrequest = ~gnt[1];
        mem_chipselect = gnt_valid & in_range;
        mem_write      = gnt_valid & sel_wr;
      end
    end
  end

  // Stage p0 -> p1: control state and pending-read flags
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= (SCRUB_ON_RESET != 0) ? ST_SCRUB : ST_SERVE;
      scrub_cnt_q  <= '0;
      last_grant_q <= 1'b1;
      pend_rd_p1   <= 2'b00;
    end else begin
      state_q      <= state_d;
      scrub_cnt_q  <= scrub_cnt_d;
      last_grant_q <= last_grant_d;
      pend_rd_p1   <= rd_acc;
    end
  end

  always_ff @(posedge clk) begin
    oor_p1 <= ~in_range;
  end

  // Stage p1: RAM q arrives; out-of-range reads return zero
  assign rd_data_p1 = oor_p1 ? '0 : mem_readdata;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_hold0_q <= '0;
      rd_hold1_q <= '0;
    end else begin
      if (pend_rd_p1[0]) rd_hold0_q <= rd_data_p1;
      if (pend_rd_p1[1]) rd_hold1_q <= rd_data_p1;
    end
  end

  always_comb begin
    m0.readdatavalid = reset_n & pend_rd_p1[0];
    m1.readdatavalid = reset_n & pend_rd_p1[1];
    m0.readdata      = '0;
    m1.readdata      = '0;
    if (reset_n) begin
      m0.readdata = pend_rd_p1[0] ? rd_data_p1 : rd_hold0_q;
      m1.readdata = pend_rd_p1[1] ? rd_data_p1 : rd_hold1_q;
    end
  end

endmodule
